// File: rtl/aes_pkg.sv
// Shared AES definitions: the block width, the block type, the serializer state encoding
// and the helper that gives the number of output words per block.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic {
    SER_EMPTY = 1'b0,
    SER_SEND  = 1'b1
  } ser_state_t;

  function automatic int words_per_block(input int out_w);
    return AES_BLOCK_W / out_w;
  endfunction
endpackage

// File: rtl/aes_block_fifo.sv
// DEPTH x 128-bit synchronous block FIFO. It also reports the occupancy and head block
// as they will be after this clock edge, so the caller can register its outputs from them.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  aes_block_t             din,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt,
  output aes_block_t             head_nxt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  aes_block_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  head_idx;
  logic           empty;
  logic           wr_en;
  logic           rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still takes a block when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en) begin
      level_nxt = level + 1'b1;
    end else if (rd_en && !wr_en) begin
      level_nxt = level - 1'b1;
    end
  end

  // The next head is the block being written now when it lands in the head slot.
  assign head_idx = rd_en ? rd_ptr + 1'b1 : rd_ptr;
  assign head_nxt = (wr_en && (wr_ptr == head_idx)) ? din : mem[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES result blocks and streams each one MSB-first as OUT_W-bit words on valid/ready.
// Defining AES_OUT_PARITY_EN adds out_par, with even parity for each byte of out_data.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  aes_block_t                  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_last,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  input  logic                        clr_ovf,
`ifdef AES_OUT_PARITY_EN
  output logic [OUT_W/8-1:0]          out_par,
`endif
  output ser_state_t                  dbg_state
);
  localparam int WPB   = words_per_block(OUT_W);
  localparam int CNT_W = $clog2(WPB);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a word moves when out_valid && out_ready on a rising edge. out_valid never
  // drops and out_data/out_last never change while a word is waiting.

  ser_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_word;
  logic             hs;
  logic             pop;
  logic             drop;
  logic             full;
  logic             valid_nxt;
  logic [LW-1:0]    level_nxt;
  aes_block_t       head_nxt;
  aes_block_t       shifted;
  logic [OUT_W-1:0] word_nxt;

  assign out_valid = (state == SER_SEND);
  assign dbg_state = state;
  assign last_word = (cnt == CNT_W'(WPB - 1));
  assign hs        = out_valid && out_ready;
  assign pop       = hs && last_word;
  assign drop      = in_valid && full && !pop;
  assign valid_nxt = (level_nxt != '0);

  aes_block_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .pop       (pop),
    .din       (in_data),
    .full      (full),
    .level     (level),
    .level_nxt (level_nxt),
    .head_nxt  (head_nxt)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (hs) begin
      cnt_nxt = last_word ? '0 : cnt + 1'b1;
    end
    shifted  = head_nxt << (int'(cnt_nxt) * OUT_W);
    word_nxt = shifted[AES_BLOCK_W-1 -: OUT_W];
  end

`ifdef AES_OUT_PARITY_EN
  logic [OUT_W/8-1:0] par_nxt;

  always_comb begin
    par_nxt = '0;
    for (int i = 0; i < OUT_W / 8; i++) begin
      par_nxt[i] = ^word_nxt[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= '0;
    end else begin
      out_par <= valid_nxt ? par_nxt : '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SER_EMPTY;
      cnt      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        SER_EMPTY: state <= valid_nxt ? SER_SEND : SER_EMPTY;
        SER_SEND:  state <= valid_nxt ? SER_SEND : SER_EMPTY;
        default:   state <= SER_EMPTY;
      endcase
      cnt      <= cnt_nxt;
      out_data <= valid_nxt ? word_nxt : '0;
      out_last <= valid_nxt && (cnt_nxt == CNT_W'(WPB - 1));
      // A new drop wins over a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer: a per-cycle vector table plus hand-written
// sequences for overflow, full-with-pop, and reset in the middle of a block.
module tb_aes_out_serializer;
  import aes_pkg::*;

  localparam int OUT_W = 32;
  localparam int LW    = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  aes_block_t       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             clr_ovf;
  ser_state_t       dbg_state;
`ifdef AES_OUT_PARITY_EN
  logic [OUT_W/8-1:0] out_par;
`endif

  aes_out_serializer #(
    .FIFO_DEPTH (4),
    .OUT_W      (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
`ifdef AES_OUT_PARITY_EN
    .out_par   (out_par),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct packed {
    logic             iv;
    logic [127:0]     id;
    logic             rdy;
    logic             clr;
    logic             ev;
    logic [OUT_W-1:0] ed;
    logic             el;
    logic [LW-1:0]    elv;
    logic             eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic [127:0] id, input logic rdy,
                              input logic ev, input logic [OUT_W-1:0] ed, input logic el,
                              input logic [LW-1:0] elv);
    vec_t v;
    v.iv = iv; v.id = id; v.rdy = rdy; v.clr = 1'b0;
    v.ev = ev; v.ed = ed; v.el = el; v.elv = elv; v.eo = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_words(input logic [127:0] blk);
    for (int k = 0; k < 128 / OUT_W; k++) begin
      exp_q.push_back(blk[127 - k*OUT_W -: OUT_W]);
    end
  endtask

  // Consume words with out_ready high until the expected queue empties or the budget runs out.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      if (out_valid) begin
        chk({name, "_word"}, out_data, exp_q.pop_front());
        chk({name, "_last"}, out_last, (exp_q.size() % (128 / OUT_W)) == 0);
      end
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    chk({name, "_idle"}, out_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] blk_a;
  logic [127:0] blk_b;
  logic [7:0]   byte_v;
  logic [127:0] fill [5];

  initial begin
    blk_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk_b = 128'h00112233445566778899aabbccddeeff;

    // single block at full speed, then a stalled block
    tbl.push_back(mk(1, blk_a, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0,     1, 1, 32'h69c4e0d8, 0, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'h6a7b0430, 0, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'hd8cdb780, 0, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'h70b4c55a, 1, 1));
    tbl.push_back(mk(0, 0,     1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, blk_b, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0,     1, 1, 32'h00112233, 0, 1));
    tbl.push_back(mk(0, 0,     0, 1, 32'h44556677, 0, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'h44556677, 0, 1));
    tbl.push_back(mk(0, 0,     0, 1, 32'h8899aabb, 0, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'h8899aabb, 0, 1));
    tbl.push_back(mk(0, 0,     0, 1, 32'hccddeeff, 1, 1));
    tbl.push_back(mk(0, 0,     1, 1, 32'hccddeeff, 1, 1));
    tbl.push_back(mk(0, 0,     1, 0, 32'h0,        0, 0));

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data,  '0);
    chk("rst_last",  out_last,  1'b0);
    chk("rst_level", level,     '0);
    chk("rst_ovf",   overflow,  1'b0);
`ifdef AES_OUT_PARITY_EN
    chk("rst_par",   out_par,   '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].rdy;
      clr_ovf   = tbl[i].clr;
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("v%0d_data", i),  out_data,  tbl[i].ed);
      chk($sformatf("v%0d_last", i),  out_last,  tbl[i].el);
      chk($sformatf("v%0d_level", i), level,     tbl[i].elv);
      chk($sformatf("v%0d_ovf", i),   overflow,  tbl[i].eo);
`ifdef AES_OUT_PARITY_EN
      chk($sformatf("v%0d_par", i), out_par,
          {^tbl[i].ed[31:24], ^tbl[i].ed[23:16], ^tbl[i].ed[15:8], ^tbl[i].ed[7:0]});
`endif
      step();
    end
    in_valid = 1'b0;

    // ---- overflow: five blocks into a depth-4 FIFO with the consumer stalled ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_v   = 8'h11 * 8'(i + 1);
      fill[i]  = {16{byte_v}};
      in_valid = 1'b1;
      in_data  = fill[i];
      step();
    end
    in_valid = 1'b0;
    chk("ovf_level", level,     3'd4);
    chk("ovf_flag",  overflow,  1'b1);
    chk("ovf_head",  out_data,  32'h11111111);
    chk("ovf_valid", out_valid, 1'b1);

    // a clear and a fresh drop in the same cycle leaves the flag set
    in_valid = 1'b1;
    in_data  = {16{8'h66}};
    clr_ovf  = 1'b1;
    step();
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    chk("setwins_ovf",   overflow, 1'b1);
    chk("setwins_level", level,    3'd4);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 1'b0);

    for (int i = 0; i < 4; i++) push_words(fill[i]);
    drain("drain_ovf", 40);
    chk("drain_ovf_level", level, '0);

    // ---- full FIFO with a write on the last-word handshake ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fill[i] = {32'(32'ha0000000 + i*16 + 0), 32'(32'ha0000000 + i*16 + 1),
                 32'(32'ha0000000 + i*16 + 2), 32'(32'ha0000000 + i*16 + 3)};
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fill[i];
      step();
    end
    in_valid = 1'b0;
    chk("full_level", level, 3'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("full_w%0d", k), out_data, fill[0][127 - k*OUT_W -: OUT_W]);
      step();
    end
    chk("full_lastflag", out_last, 1'b1);
    in_valid = 1'b1;
    in_data  = fill[4];
    step();
    in_valid = 1'b0;
    chk("full_pop_level", level,    3'd4);
    chk("full_pop_ovf",   overflow, 1'b0);
    for (int i = 1; i < 5; i++) push_words(fill[i]);
    drain("drain_full", 40);

    // ---- asynchronous reset part-way through a block ----
    in_valid = 1'b1;
    in_data  = blk_b;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("pre_rst_word", out_data, 32'h8899aabb);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_level", level,     '0);
    chk("async_rst_data",  out_data,  '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst_valid%0d", i), out_valid, 1'b0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
